fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage between the PC/instruction-memory pair and decode. Owns the
//  fetch PC and issues word reads to the synchronous instruction memory (1-cycle latency).
//  Returned words are buffered in a small prefetch queue, then assembled into 16- or
//  32-bit AAP instructions. These are presented to decode over a valid/ready handshake.
//  Branch redirects from execute flush the queue and restart fetch.
// PARAMETERS
//  ADDR_W    16      word-address width of fetch PC / imem_addr
//  DEPTH     4       prefetch queue entries (16-bit words); power of two, >= 2
//  RESET_PC  16'h0   fetch PC loaded on reset
// PORTS
//  speedy_clock    in   1       pipeline clock; all state on rising edge
//  reset_n         in   1       asynchronous, active-low reset
//  imem_rd_en      out  1       read strobe to instruction memory
//  imem_addr       out  ADDR_W  word address of read
//  imem_rdata      in   16      read data, valid the cycle after imem_rd_en
//  redirect_valid  in   1       branch taken / PC overwrite this cycle
//  redirect_pc     in   ADDR_W  new fetch word address
//  dec_valid       out  1       complete instruction at queue head
//  dec_ready       in   1       decode accepts instruction
//  dec_instr       out  32      {word1, word0}; upper half 0 for 16-bit
//  dec_is32        out  1       head instruction is 32-bit
//  dec_pc          out  ADDR_W  word address of head instruction's first word
// BEHAVIOUR
//  Reset (async, reset_n=0): fetch_pc=RESET_PC; queue empty; in-flight flag 0;
//   imem_rd_en=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_is32=0,
//   dec_pc=RESET_PC. Reset mid-operation drops all queued and in-flight words.
//  Issue: imem_rd_en=1 iff !redirect_valid && (count + inflight) < DEPTH.
//   imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+1 (mod 2^ADDR_W, wraps to 0).
//  Response: inflight set on issue. Next cycle, imem_rdata is pushed at tail unless killed.
//   Latency: issue cycle N -> word in queue end of N+1 -> dec_valid earliest N+2.
//  Queue head word0 is oldest. Queue tracks the word address of its head entry.
//  Instruction length: word0[15]=1 -> 32-bit (needs count>=2), else 16-bit (count>=1).
//  dec_valid = enough words for head instruction && !redirect_valid. Outputs are
//   combinational from queue registers. dec_pc = head address.
//  Pop: dec_valid && dec_ready removes 1 or 2 words. Head address advances by 1 or 2.
//   Push and pop in the same cycle are both honoured. Count never exceeds DEPTH
//   (guaranteed by issue credit).
//  Redirect (highest priority): in the cycle redirect_valid=1:
//   - no issue; dec_valid=0; no pop;
//   - queue cleared; any in-flight response arriving next cycle is discarded;
//   - fetch_pc <= redirect_pc; head address <= redirect_pc.
//   Issue resumes the following cycle. Back-to-back redirects: the last one wins.
//  Held outputs: dec_* stable while dec_valid && !dec_ready (no redirect).
// CONFIGURATION
//  FETCH_INSN32_EN defined: 32-bit assembly as above.
//  Not defined: every word is a 16-bit instruction, dec_is32=0, dec_instr[31:16]=0.
//   dec_valid iff count>=1; pop is always one word.
// TESTING
//  1 Reset release; imem returns 0x1234 @0, 0x0042 @1; dec_ready=1 ->
//    imem_addr 0,1,2... on consecutive cycles. dec_valid 2 cycles after first issue:
//    dec_instr=0x00001234, dec_pc=0; next cycle 0x00000042, dec_pc=1.
//  2 dec_ready=0 from reset -> exactly DEPTH(4) reads issued (addr 0..3), then imem_rd_en=0.
//    dec_valid=1 and dec_instr held. Raise dec_ready -> issue resumes at addr 4.
//  3 Words 0x8001 @0, 0x00AB @1, 0x0007 @2 (INSN32_EN) ->
//    dec_instr=0x00AB8001, dec_is32=1, dec_pc=0; then 0x00000007, dec_pc=2.
//  4 Only 0x8001 in queue with the next response delayed by back-pressure ->
//    dec_valid=0 until second word is queued.
//  5 Redirect_pc=0x0100 while a read of addr 5 is in flight and 3 words are queued ->
//    dec_valid=0 that cycle. The addr-5 response is dropped. Next imem_addr=0x0100.
//    First dec_pc after redirect=0x0100.
//  6 Redirect_pc=0xFFFF -> imem_addr 0xFFFF then 0x0000. dec_pc sequence 0xFFFF, 0x0000.
//    Repeat test 3 without FETCH_INSN32_EN -> 0x8001 emitted alone, dec_is32=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to a 1-cycle synchronous
// instruction memory, buffers returned words in a small prefetch queue and presents
// assembled 16/32-bit AAP instructions to decode over valid/ready.
// Optional feature macro: FETCH_INSN32_EN enables 32-bit instruction assembly
// (word0[15]=1). Without it every word is issued to decode as a 16-bit instruction.
module fetch_unit #(
   parameter int unsigned        ADDR_W   = 16,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              speedy_clock,
   input  logic              reset_n,
   output logic              imem_rd_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [31:0]       dec_instr,
   output logic              dec_is32,
   output logic [ADDR_W-1:0] dec_pc
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [15:0]       queue_q [DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] head_pc_q, head_pc_d;
   logic              inflight_q, inflight_d;

   logic [15:0]       word0, word1;
   logic              head_is32;
   logic [CntW-1:0]   need_cnt, pop_cnt;
   logic [CntW:0]     used;
   logic              issue, push, pop;

   // Head decode, issue credit and decode-side handshake
   always_comb begin
      word0 = queue_q[rd_ptr_q];
      word1 = queue_q[rd_ptr_q + PtrW'(1)];
`ifdef FETCH_INSN32_EN
      head_is32 = word0[15];
`else
      head_is32 = 1'b0;
`endif
      need_cnt = head_is32 ? CntW'(2) : CntW'(1);
      // Credit counts the word already in flight so the queue can never overflow
      used  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
      issue = reset_n && !redirect_valid && (used < (CntW+1)'(DEPTH));
      // A response landing during a redirect belongs to the old stream: drop it
      push  = inflight_q && !redirect_valid;
      dec_valid = !redirect_valid && (count_q >= need_cnt);
      pop       = dec_valid && dec_ready;
      pop_cnt   = pop ? need_cnt : '0;

      imem_rd_en = issue;
      imem_addr  = fetch_pc_q;
      dec_is32   = head_is32;
      dec_instr  = head_is32 ? {word1, word0} : {16'h0000, word0};
      dec_pc     = head_pc_q;
   end

   // Next-state for PC, pointers, occupancy and in-flight tracking
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_pc_d  = head_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inflight_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         head_pc_d  = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         end
         inflight_d = issue;
         rd_ptr_d   = rd_ptr_q + pop_cnt[PtrW-1:0];
         wr_ptr_d   = wr_ptr_q + PtrW'(push);
         count_d    = count_q - pop_cnt + CntW'(push);
         head_pc_d  = head_pc_q + ADDR_W'(pop_cnt);
      end
   end

   // Control state registers
   always_ff @(posedge speedy_clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         head_pc_q  <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Prefetch storage; cleared on reset so decode outputs start at zero
   always_ff @(posedge speedy_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            queue_q[i] <= '0;
         end
      end else if (push) begin
         queue_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run checked every cycle against a word-queue reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_rd_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic        dec_is32;
   logic [15:0] dec_pc;

`ifdef FETCH_INSN32_EN
   localparam bit Insn32 = 1'b1;
`else
   localparam bit Insn32 = 1'b0;
`endif
   localparam int Depth = 4;

   always #5 clk = ~clk;

   fetch_unit dut (
      .speedy_clock   (clk),
      .reset_n        (reset_n),
      .imem_rd_en     (imem_rd_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_is32       (dec_is32),
      .dec_pc         (dec_pc)
   );

   // Synchronous instruction memory, one-cycle read latency
   logic [15:0] imem [0:65535];
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= imem[imem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the words the fetch stage has accepted, oldest first
   logic [15:0] mq[$];
   bit          pend;
   logic [15:0] pend_data;
   logic [15:0] m_fetch;
   logic [15:0] m_head;
   int          accepted = 0;

   task automatic model_reset();
      mq.delete();
      pend    = 1'b0;
      m_fetch = 16'h0000;
      m_head  = 16'h0000;
   endtask

   task automatic model_step();
      int          need;
      bit          erd;
      bit          ev;
      logic [31:0] einstr;
      erd  = !redirect_valid && ((mq.size() + int'(pend)) < Depth);
      need = (Insn32 && mq.size() > 0 && mq[0][15]) ? 2 : 1;
      ev   = !redirect_valid && (mq.size() >= need);
      chk("m_rd_en", 32'(imem_rd_en), 32'(erd));
      chk("m_addr", 32'(imem_addr), 32'(m_fetch));
      chk("m_valid", 32'(dec_valid), 32'(ev));
      if (ev) begin
         einstr = (need == 2) ? {mq[1], mq[0]} : {16'h0000, mq[0]};
         chk("m_pc", 32'(dec_pc), 32'(m_head));
         chk("m_instr", dec_instr, einstr);
         chk("m_is32", 32'(dec_is32), 32'(need == 2));
      end
      if (redirect_valid) begin
         mq.delete();
         pend    = 1'b0;
         m_fetch = redirect_pc;
         m_head  = redirect_pc;
      end else begin
         if (ev && dec_ready) begin
            for (int i = 0; i < need; i++) void'(mq.pop_front());
            m_head = m_head + 16'(need);
            accepted++;
         end
         if (pend) mq.push_back(pend_data);
         if (erd) begin
            pend      = 1'b1;
            pend_data = imem[m_fetch];
            m_fetch   = m_fetch + 16'h1;
         end else begin
            pend = 1'b0;
         end
      end
   endtask

   // One cycle: drive after the edge, check at the falling edge
   task automatic cycle(input logic rdy, input logic rv, input logic [15:0] rpc);
      @(posedge clk);
      #1;
      dec_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
      model_step();
   endtask

   // Async reset pulse mid-cycle, then the first post-reset cycle
   task automatic do_reset(input logic rdy);
      @(posedge clk);
      #1;
      reset_n        = 1'b0;
      dec_ready      = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      #1;
      chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_instr", dec_instr, 32'd0);
      chk("rst_is32", 32'(dec_is32), 32'd0);
      chk("rst_pc", 32'(dec_pc), 32'd0);
      model_reset();
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      model_step();
   endtask

   task automatic default_mem();
      for (int a = 0; a < 65536; a++) imem[a] = 16'(a) & 16'h7FFF;
      imem[0] = 16'h1234;
      imem[1] = 16'h0042;
   endtask

   typedef struct packed {
      logic        rdy;
      logic        rv;
      logic [15:0] rpc;
      logic        e_rd;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [15:0] e_pc;
   } vec_t;

   vec_t tv [9];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset_n        = 1'b0;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;

      // Streaming after reset, then redirect to 0xFFFF with PC wrap
      tv[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000};
      tv[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 32'h0, 16'h0000};
      tv[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 32'h00001234, 16'h0000};
      tv[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 32'h00000042, 16'h0001};
      tv[4] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0004, 1'b0, 32'h0, 16'h0000};
      tv[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'h0, 16'h0000};
      tv[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000};
      tv[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 32'h00007FFF, 16'hFFFF};
      tv[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 32'h00001234, 16'h0000};

      default_mem();
      model_reset();

      for (int i = 0; i < 9; i++) begin
         if (i == 0) do_reset(tv[i].rdy);
         else        cycle(tv[i].rdy, tv[i].rv, tv[i].rpc);
         chk($sformatf("tv%0d_rd_en", i), 32'(imem_rd_en), 32'(tv[i].e_rd));
         chk($sformatf("tv%0d_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
         chk($sformatf("tv%0d_valid", i), 32'(dec_valid), 32'(tv[i].e_valid));
         if (tv[i].e_valid) begin
            chk($sformatf("tv%0d_instr", i), dec_instr, tv[i].e_instr);
            chk($sformatf("tv%0d_pc", i), 32'(dec_pc), 32'(tv[i].e_pc));
            chk($sformatf("tv%0d_is32", i), 32'(dec_is32), 32'd0);
         end
      end

      // Back-pressure from reset: exactly DEPTH reads, then hold and resume at 4
      do_reset(1'b0);
      chk("bp_rd0", 32'(imem_rd_en), 32'd1);
      chk("bp_addr0", 32'(imem_addr), 32'd0);
      for (int k = 1; k < 4; k++) begin
         cycle(1'b0, 1'b0, 16'h0000);
         chk($sformatf("bp_rd%0d", k), 32'(imem_rd_en), 32'd1);
         chk($sformatf("bp_addr%0d", k), 32'(imem_addr), 32'(k));
      end
      cycle(1'b0, 1'b0, 16'h0000);
      chk("bp_full_rd", 32'(imem_rd_en), 32'd0);
      cycle(1'b0, 1'b0, 16'h0000);
      chk("bp_hold_rd", 32'(imem_rd_en), 32'd0);
      chk("bp_hold_valid", 32'(dec_valid), 32'd1);
      chk("bp_hold_instr", dec_instr, 32'h00001234);
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         cycle(1'b1, 1'b0, 16'h0000);
         if (imem_rd_en) begin
            found = 1'b1;
            chk("bp_resume_addr", 32'(imem_addr), 32'd4);
         end
      end
      chk("bp_resume_seen", 32'(found), 32'd1);

      // Redirect with 3 queued words and addr 5 in flight
      do_reset(1'b0);
      for (int k = 1; k < 5; k++) cycle(1'b0, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0000);
      chk("rd_pre_rd", 32'(imem_rd_en), 32'd1);
      chk("rd_pre_addr", 32'(imem_addr), 32'd5);
      cycle(1'b1, 1'b1, 16'h0100);
      chk("rd_valid", 32'(dec_valid), 32'd0);
      chk("rd_rd_en", 32'(imem_rd_en), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("rd_new_rd", 32'(imem_rd_en), 32'd1);
      chk("rd_new_addr", 32'(imem_addr), 32'h0100);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("rd_gap_valid", 32'(dec_valid), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("rd_first_valid", 32'(dec_valid), 32'd1);
      chk("rd_first_pc", 32'(dec_pc), 32'h0100);
      chk("rd_first_instr", dec_instr, 32'h00000100);

      // 32-bit assembly and partial-instruction stall
      imem[0] = 16'h8001;
      imem[1] = 16'h00AB;
      imem[2] = 16'h0007;
      do_reset(1'b1);
      cycle(1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 16'h0000);
`ifdef FETCH_INSN32_EN
      chk("i32_partial_valid", 32'(dec_valid), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("i32_valid", 32'(dec_valid), 32'd1);
      chk("i32_instr", dec_instr, 32'h00AB8001);
      chk("i32_is32", 32'(dec_is32), 32'd1);
      chk("i32_pc", 32'(dec_pc), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("i32_next_instr", dec_instr, 32'h00000007);
      chk("i32_next_pc", 32'(dec_pc), 32'd2);
`else
      chk("i16_valid", 32'(dec_valid), 32'd1);
      chk("i16_instr", dec_instr, 32'h00008001);
      chk("i16_is32", 32'(dec_is32), 32'd0);
      chk("i16_pc", 32'(dec_pc), 32'd0);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("i16_w1_instr", dec_instr, 32'h000000AB);
      cycle(1'b1, 1'b0, 16'h0000);
      chk("i16_w2_instr", dec_instr, 32'h00000007);
      chk("i16_w2_pc", 32'(dec_pc), 32'd2);
`endif

      // Randomized run against the model, including a mid-run reset
      for (int a = 0; a < 65536; a++) imem[a] = 16'($urandom);
      accepted = 0;
      do_reset(1'b1);
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset(1'b1);
         else cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 31) == 0),
                    16'($urandom));
      end
      chk("rand_liveness", 32'(accepted > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
